// File: rtl/wb_write_queue_if.sv
// Bus bundle for the write-back queue: pipeline/MDU write requests, bank write
// port, decode forwarding lookup and occupancy.
interface wb_write_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          pipe_we;
    logic [AW-1:0] pipe_wa;
    logic [DW-1:0] pipe_wd;
    logic          mdu_valid;
    logic [AW-1:0] mdu_wa;
    logic [DW-1:0] mdu_wd;
    logic          mdu_ready;
    logic          regwrite;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic          fwd1_hit;
    logic          fwd2_hit;
    logic [DW-1:0] fwd1_data;
    logic [DW-1:0] fwd2_data;
    logic [CW-1:0] count;

    modport master (
        output pipe_we, pipe_wa, pipe_wd, mdu_valid, mdu_wa, mdu_wd, ra1, ra2,
        input  mdu_ready, regwrite, wa, wd, fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count
    );

    modport slave (
        input  pipe_we, pipe_wa, pipe_wd, mdu_valid, mdu_wa, mdu_wd, ra1, ra2,
        output mdu_ready, regwrite, wa, wd, fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count
    );
endinterface

// File: rtl/wb_write_queue.sv
// In-order write-back FIFO merging pipeline and MDU register writes, retiring
// one entry per cycle into the register bank, with forwarding of pending writes.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_write_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] ent_wa [DEPTH];
    logic [DW-1:0] ent_wd [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;

    logic          pop;
    logic          pipe_accept;
    logic          mdu_accept;
    logic [CW-1:0] free_slots;

    // The head slot counts as free because it pops on the same edge.
    always_comb begin
        pop           = (count_q != '0);
        pipe_accept   = bus.pipe_we && (bus.pipe_wa != '0);
        free_slots    = CW'(DEPTH) - count_q + CW'(pop);
        bus.mdu_ready = rst_n && (free_slots > CW'(pipe_accept));
        mdu_accept    = bus.mdu_valid && bus.mdu_ready && (bus.mdu_wa != '0);
    end

    assign bus.regwrite = !pop;
    assign bus.wa       = ent_wa[rd_ptr];
    assign bus.wd       = ent_wd[rd_ptr];
    assign bus.count    = count_q;

    // Walk from head to tail so the youngest matching entry wins.
    function automatic logic [DW:0] fwd_lookup(input logic [AW-1:0] ra);
        logic [DW:0]   res;
        logic [PW-1:0] idx;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((ra != '0) && (CW'(i) < count_q) && (ent_wa[idx] == ra))
                res = {1'b1, ent_wd[idx]};
        end
        return res;
    endfunction

    always_comb begin
        {bus.fwd1_hit, bus.fwd1_data} = fwd_lookup(bus.ra1);
        {bus.fwd2_hit, bus.fwd2_data} = fwd_lookup(bus.ra2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_wa[i] <= '0;
                ent_wd[i] <= '0;
            end
        end else begin
            if (pipe_accept) begin
                ent_wa[wr_ptr] <= bus.pipe_wa;
                ent_wd[wr_ptr] <= bus.pipe_wd;
            end
            if (mdu_accept) begin
                ent_wa[wr_ptr + PW'(pipe_accept)] <= bus.mdu_wa;
                ent_wd[wr_ptr + PW'(pipe_accept)] <= bus.mdu_wd;
            end
            rd_ptr  <= rd_ptr + PW'(pop);
            wr_ptr  <= wr_ptr + PW'(pipe_accept) + PW'(mdu_accept);
            count_q <= count_q - CW'(pop) + CW'(pipe_accept) + CW'(mdu_accept);
        end
    end
endmodule

// File: tb/tb_wb_write_queue.sv
// Randomized bench for wb_write_queue against a queue-based reference model of
// the pending writes, plus directed scenarios for retire, ordering, $0 and reset.
module tb_wb_write_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } ent_t;

    logic clk;
    logic rst_n;

    wb_write_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    wb_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    ent_t mq[$];
    logic mdu_xfer;
    int   max_count;

    logic          mv_r;
    logic [AW-1:0] mwa_r;
    logic [DW-1:0] mwd_r;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare all outputs against the model
    // mid-cycle, then advance the model across the rising edge.
    task automatic step(input logic pwe, input logic [AW-1:0] pwa, input logic [DW-1:0] pwd,
                        input logic mv, input logic [AW-1:0] mwa, input logic [DW-1:0] mwd,
                        input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        int   sz;
        int   exp_free;
        logic pa;
        logic exp_rdy;
        logic h1, h2;
        logic [DW-1:0] d1, d2;
        bus.pipe_we   = pwe;
        bus.pipe_wa   = pwa;
        bus.pipe_wd   = pwd;
        bus.mdu_valid = mv;
        bus.mdu_wa    = mwa;
        bus.mdu_wd    = mwd;
        bus.ra1       = r1;
        bus.ra2       = r2;
        @(negedge clk);
        sz       = mq.size();
        exp_free = DEPTH - sz + ((sz != 0) ? 1 : 0);
        pa       = pwe && (pwa != 0);
        exp_rdy  = (exp_free - int'(pa)) >= 1;
        h1 = 1'b0; h2 = 1'b0; d1 = '0; d2 = '0;
        for (int i = 0; i < sz; i++) begin
            if (r1 != 0 && mq[i].wa == r1) begin h1 = 1'b1; d1 = mq[i].wd; end
            if (r2 != 0 && mq[i].wa == r2) begin h2 = 1'b1; d2 = mq[i].wd; end
        end
        check("count", 64'(bus.count), 64'(sz));
        check("count_le_depth", 64'(bus.count <= DEPTH), 64'(1));
        check("regwrite", 64'(bus.regwrite), 64'(sz == 0));
        if (sz != 0) begin
            check("wa_head", 64'(bus.wa), 64'(mq[0].wa));
            check("wd_head", 64'(bus.wd), 64'(mq[0].wd));
        end
        check("mdu_ready", 64'(bus.mdu_ready), 64'(exp_rdy));
        check("fwd1_hit", 64'(bus.fwd1_hit), 64'(h1));
        check("fwd1_data", 64'(bus.fwd1_data), 64'(d1));
        check("fwd2_hit", 64'(bus.fwd2_hit), 64'(h2));
        check("fwd2_data", 64'(bus.fwd2_data), 64'(d2));
        if (int'(bus.count) > max_count) max_count = int'(bus.count);
        mdu_xfer = mv && exp_rdy;
        @(posedge clk);
        if (sz != 0) void'(mq.pop_front());
        if (pa) mq.push_back(ent_t'({pwa, pwd}));
        if (mdu_xfer && mwa != 0) mq.push_back(ent_t'({mwa, mwd}));
        #1;
    endtask

    task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        step(1'b0, '0, '0, 1'b0, '0, '0, r1, r2);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.pipe_we   = 1'b0;
        bus.pipe_wa   = '0;
        bus.pipe_wd   = '0;
        bus.mdu_valid = 1'b0;
        bus.mdu_wa    = '0;
        bus.mdu_wd    = '0;
        bus.ra1       = 5'd5;
        bus.ra2       = '0;
        mv_r          = 1'b0;
        mwa_r         = '0;
        mwd_r         = '0;
        max_count     = 0;
        mdu_xfer      = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_mdu_ready", 64'(bus.mdu_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset then idle
        check("idle_regwrite", 64'(bus.regwrite), 64'(1));
        check("idle_count", 64'(bus.count), 64'(0));
        check("idle_mdu_ready", 64'(bus.mdu_ready), 64'(1));
        check("idle_fwd1_hit", 64'(bus.fwd1_hit), 64'(0));
        idle(5'd5, 5'd0);

        // Single pipeline write retires one cycle later
        step(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, '0, '0, 5'd3, 5'd0);
        check("single_regwrite", 64'(bus.regwrite), 64'(0));
        check("single_wa", 64'(bus.wa), 64'(3));
        check("single_wd", 64'(bus.wd), 64'hDEADBEEF);
        check("single_count", 64'(bus.count), 64'(1));
        idle(5'd3, 5'd0);
        check("single_done_regwrite", 64'(bus.regwrite), 64'(1));
        check("single_done_count", 64'(bus.count), 64'(0));

        // Pipeline and MDU to the same register in one cycle
        step(1'b1, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22, 5'd0, 5'd0);
        bus.ra1 = 5'd4;
        #1;
        check("dual_fwd1_hit", 64'(bus.fwd1_hit), 64'(1));
        check("dual_fwd1_data", 64'(bus.fwd1_data), 64'h22);
        check("dual_first_wd", 64'(bus.wd), 64'h11);
        check("dual_count", 64'(bus.count), 64'(2));
        idle(5'd4, 5'd4);
        check("dual_second_wd", 64'(bus.wd), 64'h22);
        check("dual_second_count", 64'(bus.count), 64'(1));
        idle(5'd4, 5'd0);

        // Writes to $0 are dropped, MDU handshake still completes
        bus.pipe_we   = 1'b1;
        bus.pipe_wa   = '0;
        bus.pipe_wd   = 32'hFFFFFFFF;
        bus.mdu_valid = 1'b1;
        bus.mdu_wa    = '0;
        bus.mdu_wd    = 32'hFFFFFFFF;
        bus.ra1       = '0;
        #1;
        check("zero_mdu_ready", 64'(bus.mdu_ready), 64'(1));
        check("zero_fwd1_hit", 64'(bus.fwd1_hit), 64'(0));
        step(1'b1, '0, 32'hFFFFFFFF, 1'b1, '0, 32'hFFFFFFFF, 5'd0, 5'd0);
        check("zero_count", 64'(bus.count), 64'(0));

        // Full-throughput stress: pipeline every cycle, MDU always valid
        max_count = 0;
        for (int c = 0; c < 24; c++) begin
            if (!mv_r) begin
                mv_r  = 1'b1;
                mwa_r = AW'($urandom_range(1, 31));
                mwd_r = $urandom;
            end
            step(1'b1, AW'($urandom_range(1, 31)), $urandom, mv_r, mwa_r, mwd_r,
                 AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
            if (mdu_xfer) mv_r = 1'b0;
        end
        check("stress_max_count", 64'(max_count), 64'(DEPTH));
        mv_r = 1'b0;
        repeat (DEPTH + 1) idle(5'd0, 5'd0);

        // Randomized traffic on a small register range to provoke hits and $0
        for (int c = 0; c < 400; c++) begin
            if (!mv_r && $urandom_range(0, 2) == 0) begin
                mv_r  = 1'b1;
                mwa_r = AW'($urandom_range(0, 7));
                mwd_r = $urandom;
            end
            step($urandom_range(0, 9) < 6, AW'($urandom_range(0, 7)), $urandom,
                 mv_r, mwa_r, mwd_r, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            if (mdu_xfer) mv_r = 1'b0;
        end
        mv_r = 1'b0;
        repeat (DEPTH + 1) idle(5'd0, 5'd0);

        // Asynchronous reset with three pending writes
        step(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, 5'd0, 5'd0);
        step(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4, 5'd0, 5'd0);
        check("prereset_count", 64'(bus.count), 64'(3));
        bus.pipe_we   = 1'b0;
        bus.mdu_valid = 1'b0;
        bus.ra1       = 5'd3;
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_count", 64'(bus.count), 64'(0));
        check("areset_regwrite", 64'(bus.regwrite), 64'(1));
        check("areset_wa", 64'(bus.wa), 64'(0));
        check("areset_wd", 64'(bus.wd), 64'(0));
        check("areset_mdu_ready", 64'(bus.mdu_ready), 64'(0));
        check("areset_fwd1_hit", 64'(bus.fwd1_hit), 64'(0));
        check("areset_fwd1_data", 64'(bus.fwd1_data), 64'(0));
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) idle(5'd3, 5'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Write-back queue between the execute/memory stages and the register bank write port (regwrite active-low, wa, wd).
- Merges register writes from the single-cycle pipeline and the multi-cycle mult/div unit (MDU) into an in-order FIFO.
- Retires one write per cycle into the bank.
- Provides forwarding lookup so decode reads see pending, not-yet-retired writes.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2
- AW, 5, register address width
- DW, 32, register data width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pipe_we  in  1  pipeline write request; always accepted, no backpressure
- pipe_wa  in  AW  pipeline destination register
- pipe_wd  in  DW  pipeline write data
- mdu_valid  in  1  MDU result valid
- mdu_wa  in  AW  MDU destination register
- mdu_wd  in  DW  MDU result data
- mdu_ready  out  1  queue accepts MDU result this cycle
- regwrite  out  1  to bank; active-low write strobe, 0 = write head entry
- wa  out  AW  to bank; head entry address
- wd  out  DW  to bank; head entry data
- ra1, ra2  in  AW  decode read addresses, same values as the bank read ports
- fwd1_hit, fwd2_hit  out  1  pending write exists for ra1/ra2
- fwd1_data, fwd2_data  out  DW  youngest pending data for ra1/ra2
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, rst_n=0):
  - count=0, rd/wr pointers=0, all entries cleared to wa=0, wd=0.
  - regwrite=1 (no write), wa=0, wd=0, fwd*_hit=0, fwd*_data=0, mdu_ready=0.
  - Reset mid-operation discards all pending writes immediately.
- Retire:
  - regwrite = 0 whenever count != 0; wa/wd = head entry (registered state, no combinational path from inputs).
  - Head pops at every clk edge with count != 0, so the bank captures it on that same edge.
- Latency: write enqueued at edge N on an empty queue -> regwrite low during cycle N..N+1 -> bank written at edge N+1.
- Enqueue order per cycle:
  - Pipeline entry first (older), MDU entry second (younger).
  - Both may enqueue in one cycle.
  - Enqueue and pop in the same cycle are allowed.
- Free-slot arithmetic:
  - free = DEPTH - count + (count!=0 ? 1 : 0).
  - free >= 1 always, so a pipeline write always fits.
  - mdu_ready = (free - pipe_accept) >= 1, where pipe_accept = pipe_we & (pipe_wa != 0). Combinational from count, pipe_we, pipe_wa.
  - MDU transfer occurs when mdu_valid & mdu_ready; the MDU must hold valid/wa/wd until transfer.
- Register $0:
  - Writes with wa==0 from either source are dropped and never enqueued.
  - An MDU transfer to $0 still completes (mdu_ready per formula; pipe_accept excludes $0).
- count update: count_next = count - pop + pipe_accept + mdu_accept. Never exceeds DEPTH. Pointers wrap modulo DEPTH.
- Forwarding (combinational):
  - fwdN_hit = 1 iff raN != 0 and any occupied entry (head included) has wa == raN.
  - fwdN_data = data of the youngest matching entry; 0 when no hit.
  - Same-cycle incoming writes are NOT forwarded; the pipeline handles that bypass.
- No overflow or underflow state is reachable; the bench asserts count <= DEPTH every cycle.

Test Plan:
- Reset then idle -> regwrite=1, count=0, mdu_ready=1, fwd1_hit=0 for ra1=5.
- pipe_we=1, wa=3, wd=0xDEADBEEF for one cycle -> next cycle regwrite=0, wa=3, wd=0xDEADBEEF, count=1; following cycle regwrite=1, count=0.
- Same cycle: pipe (wa=4, 0x11) and MDU (wa=4, 0x22) -> retire order 0x11 then 0x22; while both are pending, ra1=4 gives fwd1_hit=1, fwd1_data=0x22.
- Full-throughput stress:
  - pipe_we every cycle plus mdu_valid held high -> count saturates at DEPTH=4.
  - mdu_ready=0 while full with pipe_we=1 to a nonzero register; pipe writes are never lost.
  - All writes retire in enqueue order.
- pipe_wa=0 and MDU wa=0 with data 0xFFFFFFFF -> nothing enqueued, count unchanged, MDU handshake completes in 1 cycle, ra1=0 gives fwd1_hit=0.
- Queue holding 3 entries, rst_n pulsed low mid-cycle (asynchronous) -> immediately count=0, regwrite=1, wa=0, wd=0; no bank write after reset release.
